// File: rtl/z80_io_pkg.sv
// Shared constants for the Z80 I/O bus initiator: opcodes,
// bus-cycle state encoding and the "no data" read value.
package z80_io_pkg;

  localparam logic [1:0] OP_WR     = 2'b00;
  localparam logic [1:0] OP_RD     = 2'b01;
  localparam logic [1:0] OP_INTACK = 2'b10;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE = 3'd0;
  localparam state_t S_T1   = 3'd1;
  localparam state_t S_T2   = 3'd2;
  localparam state_t S_TW   = 3'd3;
  localparam state_t S_T3   = 3'd4;

  // Returned when a read/intack sees no oe_n (sliced to DWID).
  localparam logic [31:0] NO_DATA = '1;

endpackage

// File: rtl/z80_io_sync.sv
// Two-flop synchronizer, synchronous active-low reset to 0.
// Ports: clk, reset_n, d (async in), q (synchronized out).
module z80_io_sync (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic s1;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1 <= 1'b0;
      q  <= 1'b0;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule

// File: rtl/z80_io_master.sv
// Z80-style I/O bus initiator: write, read and intack cycles
// from a cmd/rsp interface. Ports: clk, reset_n (sync, low),
// cmd_* (request), rsp_* (completion), bus_* / strobes (bus),
// int_n -> irq_pending. Option: Z80_IO_AUTO_INTACK_EN.
module z80_io_master
  import z80_io_pkg::*;
#(
  parameter int DWID     = 8,
  parameter int AWID     = 8,
  parameter int WAIT_CYC = 1
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [1:0]      cmd_op,
  input  logic [AWID-1:0] cmd_addr,
  input  logic [DWID-1:0] cmd_wdata,
  output logic            rsp_valid,
  output logic [1:0]      rsp_op,
  output logic [DWID-1:0] rsp_data,
  output logic            rsp_err,
  output logic [AWID-1:0] bus_addr,
  output logic [DWID-1:0] bus_dout,
  output logic            bus_doe,
  input  logic [DWID-1:0] bus_din,
  input  logic            oe_n,
  output logic            iorq_n,
  output logic            rd_n,
  output logic            wr_n,
  output logic            m1_n,
  input  logic            int_n,
  output logic            irq_pending
);

  localparam int TWL = (WAIT_CYC > 0) ? WAIT_CYC - 1 : 0;

  state_t          state;
  state_t          nxt;
  logic [3:0]      tw_cnt;
  logic [1:0]      op;
  logic            cap;
  logic [DWID-1:0] cap_data;
  logic [1:0]      hold;
  logic            alive;
  logic            irq_s;
  logic            accept;
  logic            start_auto;
  logic            go;
  logic [1:0]      go_op;
  logic [1:0]      nop;
  logic            str;
  logic            busy;
  logic            win;

  z80_io_sync u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (!int_n),
    .q       (irq_s)
  );

  // Holdoff masks the stale request while int_n release
  // travels through the synchronizer.
  assign irq_pending = irq_s && (hold == 2'd0);

`ifdef Z80_IO_AUTO_INTACK_EN
  assign cmd_ready  = alive && (state == S_IDLE) && !irq_pending;
  assign start_auto = alive && (state == S_IDLE) && irq_pending;
`else
  assign cmd_ready  = alive && (state == S_IDLE);
  assign start_auto = 1'b0;
`endif

  assign accept = cmd_valid && cmd_ready;
  assign go     = accept || start_auto;
  assign go_op  = start_auto ? OP_INTACK : cmd_op;

  always_comb begin
    nxt = state;
    unique case (1'b1)
      (state == S_IDLE): if (go) nxt = S_T1;
      (state == S_T1):   nxt = S_T2;
      (state == S_T2):   nxt = (WAIT_CYC == 0) ? S_T3 : S_TW;
      (state == S_TW):   if (tw_cnt == TWL[3:0]) nxt = S_T3;
      (state == S_T3):   nxt = S_IDLE;
      default:           nxt = S_IDLE;
    endcase
  end

  // Strobes are registered from the next state, so the op in
  // effect next cycle is the one being accepted now.
  assign nop  = (state == S_IDLE) ? go_op : op;
  assign str  = (nxt == S_T2) || (nxt == S_TW);
  assign busy = (nxt != S_IDLE);
  assign win  = (state == S_T2) || (state == S_TW) ||
                (state == S_T3);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      alive     <= 1'b0;
      tw_cnt    <= '0;
      op        <= OP_WR;
      cap       <= 1'b0;
      cap_data  <= '0;
      hold      <= '0;
      bus_addr  <= '0;
      bus_dout  <= '0;
      bus_doe   <= 1'b0;
      iorq_n    <= 1'b1;
      rd_n      <= 1'b1;
      wr_n      <= 1'b1;
      m1_n      <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_op    <= '0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
    end else begin
      alive <= 1'b1;
      state <= nxt;
      if (go) begin
        op  <= go_op;
        cap <= 1'b0;
        bus_addr <= start_auto ? '0 : cmd_addr;
        bus_dout <= start_auto ? '0 : cmd_wdata;
      end
      if (state == S_T2)
        tw_cnt <= '0;
      else if (state == S_TW)
        tw_cnt <= tw_cnt + 4'd1;
      iorq_n  <= !str;
      rd_n    <= !(str && (nop != OP_WR));
      wr_n    <= !(str && (nop == OP_WR));
      m1_n    <= !(busy && (nop == OP_INTACK));
      bus_doe <= busy && (nop == OP_WR);
      if (win && !oe_n && !cap) begin
        cap      <= 1'b1;
        cap_data <= bus_din;
      end
      rsp_valid <= (state == S_T3);
      if (state == S_T3) begin
        rsp_op <= op;
        if (cap) begin
          rsp_data <= cap_data;
          rsp_err  <= 1'b0;
        end else if (!oe_n) begin
          rsp_data <= bus_din;
          rsp_err  <= 1'b0;
        end else begin
          rsp_data <= NO_DATA[DWID-1:0];
          rsp_err  <= (op != OP_WR);
        end
      end
      if ((state == S_T3) && (op == OP_INTACK))
        hold <= 2'd3;
      else if (hold != 2'd0)
        hold <= hold - 2'd1;
    end
  end

endmodule

// File: tb/tb_z80_io_master.sv
// Directed bench for z80_io_master (WAIT_CYC = 1).
// Cycle 0 = accept cycle; outputs sampled on negedge.
module tb_z80_io_master;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [7:0] cmd_addr;
  logic [7:0] cmd_wdata;
  logic       rsp_valid;
  logic [1:0] rsp_op;
  logic [7:0] rsp_data;
  logic       rsp_err;
  logic [7:0] bus_addr;
  logic [7:0] bus_dout;
  logic       bus_doe;
  logic [7:0] bus_din;
  logic       oe_n;
  logic       iorq_n;
  logic       rd_n;
  logic       wr_n;
  logic       m1_n;
  logic       int_n;
  logic       irq_pending;

  always #5 clk = ~clk;

  z80_io_master #(
    .DWID(8), .AWID(8), .WAIT_CYC(1)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_addr    (cmd_addr),
    .cmd_wdata   (cmd_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_op      (rsp_op),
    .rsp_data    (rsp_data),
    .rsp_err     (rsp_err),
    .bus_addr    (bus_addr),
    .bus_dout    (bus_dout),
    .bus_doe     (bus_doe),
    .bus_din     (bus_din),
    .oe_n        (oe_n),
    .iorq_n      (iorq_n),
    .rd_n        (rd_n),
    .wr_n        (wr_n),
    .m1_n        (m1_n),
    .int_n       (int_n),
    .irq_pending (irq_pending)
  );

  int n_chk = 0;
  int n_err = 0;

  logic [15:0] lo_iorq, lo_rd, lo_wr, lo_m1;
  logic [15:0] m_doe, m_rv, m_irq;
  logic [7:0]  addr1, dout1, dout4;
  logic [1:0]  rop  [2];
  logic [7:0]  rdat [2];
  logic        rerr [2];
  int          nrsp;
  int          acc_c;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic [1:0] op,
                       input logic [7:0] a,
                       input logic [7:0] d);
    int t;
    cmd_op    = op;
    cmd_addr  = a;
    cmd_wdata = d;
    cmd_valid = 1'b1;
    t = 0;
    @(negedge clk);
    while (!cmd_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("accept_wait", 32'(t < 20), 1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic mon(input int ncyc, input int oe_cyc,
                     input logic [7:0] din, input int rel_cyc);
    logic drop;
    lo_iorq = '0; lo_rd = '0; lo_wr = '0; lo_m1 = '0;
    m_doe = '0; m_rv = '0; m_irq = '0;
    nrsp = 0;
    acc_c = -1;
    for (int c = 1; c <= ncyc; c++) begin
      oe_n    = (c == oe_cyc) ? 1'b0 : 1'b1;
      bus_din = (c == oe_cyc) ? din : 8'h00;
      if (c == rel_cyc) int_n = 1'b1;
      @(negedge clk);
      lo_iorq[c] = !iorq_n;
      lo_rd[c]   = !rd_n;
      lo_wr[c]   = !wr_n;
      lo_m1[c]   = !m1_n;
      m_doe[c]   = bus_doe;
      m_rv[c]    = rsp_valid;
      m_irq[c]   = irq_pending;
      if (c == 1) begin
        addr1 = bus_addr;
        dout1 = bus_dout;
      end
      if (c == 4) dout4 = bus_dout;
      if (rsp_valid && nrsp < 2) begin
        rop[nrsp]  = rsp_op;
        rdat[nrsp] = rsp_data;
        rerr[nrsp] = rsp_err;
        nrsp++;
      end
      drop = cmd_valid && cmd_ready;
      if (drop && acc_c < 0) acc_c = c;
      @(posedge clk); #1;
      if (drop) cmd_valid = 1'b0;
    end
    oe_n = 1'b1;
  endtask

  initial begin
    int acc [3];
    int n, gap, mingap;
    logic seen;
    reset_n   = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    cmd_addr  = 8'h00;
    cmd_wdata = 8'h00;
    bus_din   = 8'h00;
    oe_n      = 1'b1;
    int_n     = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_iorq", iorq_n, 1);
    chk("rst_m1", m1_n, 1);
    chk("rst_ready", cmd_ready, 0);
    chk("rst_addr", bus_addr, 0);
    chk("rst_rdata", rsp_data, 0);
    chk("rst_rvalid", rsp_valid, 0);
    chk("rst_irq", irq_pending, 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk);
    chk("rel_ready0", cmd_ready, 0);
    @(negedge clk);
    chk("rel_ready1", cmd_ready, 1);
    @(posedge clk); #1;

    issue(2'b00, 8'h10, 8'h85);
    mon(7, 0, 8'h00, 0);
    chk("wr_iorq", lo_iorq, 16'h000C);
    chk("wr_wr", lo_wr, 16'h000C);
    chk("wr_rd", lo_rd, 16'h0000);
    chk("wr_m1", lo_m1, 16'h0000);
    chk("wr_doe", m_doe, 16'h001E);
    chk("wr_rv", m_rv, 16'h0020);
    chk("wr_addr", addr1, 8'h10);
    chk("wr_dout1", dout1, 8'h85);
    chk("wr_dout4", dout4, 8'h85);
    chk("wr_op", rop[0], 2'b00);
    chk("wr_err", rerr[0], 0);

    issue(2'b01, 8'h11, 8'h00);
    mon(7, 3, 8'h3C, 0);
    chk("rd_rd", lo_rd, 16'h000C);
    chk("rd_wr", lo_wr, 16'h0000);
    chk("rd_doe", m_doe, 16'h0000);
    chk("rd_rv", m_rv, 16'h0020);
    chk("rd_addr", addr1, 8'h11);
    chk("rd_op", rop[0], 2'b01);
    chk("rd_data", rdat[0], 8'h3C);
    chk("rd_err", rerr[0], 0);

    issue(2'b01, 8'h12, 8'h00);
    mon(7, 0, 8'h00, 0);
    chk("to_data", rdat[0], 8'hFF);
    chk("to_err", rerr[0], 1);

    issue(2'b01, 8'h13, 8'h00);
    mon(7, 4, 8'h5A, 0);
    chk("t3_data", rdat[0], 8'h5A);
    chk("t3_err", rerr[0], 0);

    issue(2'b01, 8'h14, 8'h00);
    mon(7, 5, 8'h66, 0);
    chk("late_data", rdat[0], 8'hFF);
    chk("late_err", rerr[0], 1);

    issue(2'b10, 8'h00, 8'h00);
    mon(7, 3, 8'hA2, 0);
    chk("ia_m1", lo_m1, 16'h001E);
    chk("ia_rd", lo_rd, 16'h000C);
    chk("ia_iorq", lo_iorq, 16'h000C);
    chk("ia_op", rop[0], 2'b10);
    chk("ia_data", rdat[0], 8'hA2);

    issue(2'b11, 8'h15, 8'h00);
    mon(7, 3, 8'h77, 0);
    chk("rsv_rd", lo_rd, 16'h000C);
    chk("rsv_m1", lo_m1, 16'h0000);
    chk("rsv_data", rdat[0], 8'h77);

`ifdef Z80_IO_AUTO_INTACK_EN
    int_n = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    cmd_op    = 2'b00;
    cmd_addr  = 8'h30;
    cmd_wdata = 8'h44;
    cmd_valid = 1'b1;
    @(negedge clk);
    chk("auto_irq", irq_pending, 1);
    chk("auto_ready", cmd_ready, 0);
    @(posedge clk); #1;
    mon(14, 3, 8'hA2, 4);
    chk("auto_m1", lo_m1, 16'h001E);
    chk("auto_rd", lo_rd, 16'h000C);
    chk("auto_wr", lo_wr, 16'h0180);
    chk("auto_rv", m_rv, 16'h0420);
    chk("auto_op0", rop[0], 2'b10);
    chk("auto_dat0", rdat[0], 8'hA2);
    chk("auto_op1", rop[1], 2'b00);
    chk("auto_acc", acc_c, 5);
`else
    int_n = 1'b0;
    @(negedge clk);
    chk("irq_sync0", irq_pending, 0);
    @(negedge clk);
    chk("irq_sync1", irq_pending, 0);
    @(negedge clk);
    chk("irq_sync2", irq_pending, 1);
    @(posedge clk); #1;
    issue(2'b10, 8'h00, 8'h00);
    mon(9, 3, 8'hA2, 0);
    chk("hold_irq", m_irq, 16'h031E);
    chk("hold_data", rdat[0], 8'hA2);
    int_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
`endif

    cmd_op    = 2'b00;
    cmd_addr  = 8'h20;
    cmd_wdata = 8'h30;
    cmd_valid = 1'b1;
    n = 0;
    gap = 0;
    mingap = 99;
    seen = 1'b0;
    for (int cyc = 0; cyc < 25; cyc++) begin
      @(negedge clk);
      if (!iorq_n) begin
        if (seen && gap > 0 && gap < mingap) mingap = gap;
        seen = 1'b1;
        gap = 0;
      end else begin
        gap++;
      end
      if (cmd_valid && cmd_ready && n < 3) begin
        acc[n] = cyc;
        n++;
      end
      @(posedge clk); #1;
      if (n >= 3) cmd_valid = 1'b0;
      else cmd_wdata = 8'(8'h30 + n);
    end
    chk("b2b_count", n, 3);
    if (n == 3) begin
      chk("b2b_d1", acc[1] - acc[0], 5);
      chk("b2b_d2", acc[2] - acc[1], 5);
    end
    chk("b2b_gap", 32'(mingap >= 2 && mingap < 99), 1);

    issue(2'b01, 8'h40, 8'h00);
    @(negedge clk);
    @(posedge clk); #1;
    reset_n = 1'b0;
    @(negedge clk);
    chk("mid_rd_low", rd_n, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("mid_iorq", iorq_n, 1);
    chk("mid_rd", rd_n, 1);
    chk("mid_rv", rsp_valid, 0);
    chk("mid_ready", cmd_ready, 0);
    chk("mid_addr", bus_addr, 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk);
    chk("mid_rel_rdy0", cmd_ready, 0);
    chk("mid_rel_rv0", rsp_valid, 0);
    @(negedge clk);
    chk("mid_rel_rdy1", cmd_ready, 1);
    chk("mid_rel_rv1", rsp_valid, 0);
    chk("mid_rel_m1", m1_n, 1);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/z80_io_master.md
# z80_io_master

Synthesizable Z80-style I/O bus initiator that drives the peripheral side of the bus (`iorq_n`, `rd_n`, `wr_n`, `m1_n`, address, data) from a simple command/response interface. It issues I/O write cycles, I/O read cycles and interrupt-acknowledge (intack) cycles. It sits upstream of the CTC channels and the other Z80 peripherals, either as a CPU stand-in in the SoC or as the bus driver in benches.

## Interface
- `DWID`, 8, data width.
- `AWID`, 8, I/O address width.
- `WAIT_CYC`, 1, extra strobe cycles (TW states); legal range 0..15.

Ports:
- `clk`  in  1  single clock.
- `reset_n`  in  1  **synchronous, active-low** reset.
- `cmd_valid`  in  1  command request.
- `cmd_ready`  out  1  high only in IDLE and when no auto-intack is taking priority.
- `cmd_op`  in  2  command opcode: 00 = write, 01 = read, 10 = intack, 11 = reserved (treated as read).
- `cmd_addr`  in  AWID  I/O address.
- `cmd_wdata`  in  DWID  write data.
- `rsp_valid`  out  1  one-cycle completion pulse.
- `rsp_op`  out  2  opcode of the completed cycle.
- `rsp_data`  out  DWID  captured read data or vector.
- `rsp_err`  out  1  read/intack completed with no `oe_n` low seen.
- `bus_addr`  out  AWID  address, held from T1 through T3.
- `bus_dout`  out  DWID  write data, held from T1 through T3.
- `bus_doe`  out  1  master drives the data bus (writes only).
- `bus_din`  in  DWID  peripheral read data.
- `oe_n`  in  1  peripheral data-valid, active low.
- `iorq_n`, `rd_n`, `wr_n`, `m1_n`  out  1 each  bus strobes, active low.
- `int_n`  in  1  wired interrupt request, active low.
- `irq_pending`  out  1  synchronized `!int_n`.

## Operation
- **States:** IDLE → T1 → T2 → TW (WAIT_CYC cycles) → T3 → IDLE.
- **Accept:** a command is accepted on `cmd_valid && cmd_ready`. Opcode, address and data are registered and held until the next accept.
- **T1:** `bus_addr` is driven. For writes, `bus_dout` and `bus_doe` are also driven. For intack, `m1_n` goes low.
- **T2/TW:** `iorq_n` is low.
  - Write: `wr_n` low, `rd_n` high, `m1_n` high.
  - Read: `rd_n` low, `m1_n` high.
  - Intack: `rd_n` low and `m1_n` low. The codebase's peripherals decode intack as `!m1_n && !iorq_n && !rd_n`.
- **T3:** all strobes return high except `m1_n`, which stays low for intack. Address and data are still held.
- **Capture window (T2, TW, T3):** the first cycle with `oe_n == 0` latches `bus_din`; later `oe_n` pulses are ignored. If the window closes with no capture, `rsp_data` is all ones and `rsp_err` is 1. Writes never set `rsp_err`.
- **Return to IDLE:** `rsp_valid` pulses with `rsp_op`, `rsp_data` and `rsp_err`. `rsp_data` holds its value until the next completion. `bus_doe` drops and `m1_n` returns high.
- **irq_pending:** `int_n` passes through the two-flop synchronizer `z80_io_sync`. After any intack completes, `irq_pending` is forced low for 3 cycles so the peripheral's `int_n` release can propagate.
- **Reset:** applies on the clock edge, including mid-cycle. The cycle in progress is abandoned with no `rsp_valid`. Reset values:
  - strobes = 1
  - `bus_addr`, `bus_dout`, `rsp_data`, `rsp_op` = 0
  - `bus_doe`, `rsp_valid`, `rsp_err`, `irq_pending`, `cmd_ready` = 0
  - `cmd_ready` rises on the first cycle after reset deasserts.

## Timing
- Accept cycle = 0, T1 = 1, strobes low in cycles 2 .. 2+WAIT_CYC, T3 = 3+WAIT_CYC, `rsp_valid` (in IDLE) = 4+WAIT_CYC.
- A new command can be accepted in the same cycle as `rsp_valid`, so the minimum command period is 4+WAIT_CYC cycles.
- Strobes are high for at least 2 cycles between bus cycles, which satisfies the peripheral edge detectors.
- With WAIT_CYC = 0, a peripheral that registers its data one cycle after the strobe edge is captured in T3.
- Strobes are registered outputs; no output has a combinational path from an input except `cmd_ready`, which depends on state only.

## Configuration
- **`Z80_IO_AUTO_INTACK_EN` defined:** in IDLE with `irq_pending` = 1, the master starts an intack cycle on its own.
  - Auto-intack has priority over a simultaneous `cmd_valid`, and `cmd_ready` is 0 in that cycle.
  - Completion reports `rsp_op` = 10.
- **Not defined:** `int_n` only drives `irq_pending`; intack happens only via `cmd_op` = 10.

## Structure
- **Package `z80_io_pkg`:** opcode localparams (`OP_WR`, `OP_RD`, `OP_INTACK`), the state typedef/encoding (IDLE, T1, T2, TW, T3), and the all-ones no-data constant.
- **Sub-module `z80_io_sync`:** two-flop synchronizer with synchronous active-low reset, reset value 0, used for `int_n`.
- The state machine, TW counter, capture flag and holdoff counter live in the top module.

## Test plan
- **Write, WAIT_CYC = 1:** addr 0x10, data 0x85 → `wr_n`/`iorq_n` low cycles 2–3, `bus_dout` = 0x85 cycles 1–4, `rd_n` high throughout, `rsp_valid` at cycle 5, `rsp_err` = 0.
- **Read:** addr 0x11, bus model drives `oe_n` low with 0x3C in cycle 3 → `rsp_data` = 0x3C, `rsp_err` = 0, `rsp_valid` at cycle 5.
- **Read timeout:** `oe_n` held high → `rsp_data` = 0xFF, `rsp_err` = 1.
- **Intack with `Z80_IO_AUTO_INTACK_EN`:** assert `int_n` low while a write is also pending; peripheral returns vector 0xA2 → intack runs first with `m1_n` low cycles 1–4 and `rd_n`/`iorq_n` low; `rsp_op` = 10, `rsp_data` = 0xA2; `int_n` released → no second intack; the queued write follows.
- **Back-to-back:** 3 writes with `cmd_valid` held high → accepts 5 cycles apart, strobes high ≥ 2 cycles between bus cycles.
- **Reset mid-read:** `reset_n` low in cycle 2 → all strobes high next cycle, no `rsp_valid`; `cmd_ready` = 1 one cycle after release.
